// File: rtl/button_conditioner_pkg.sv
// Shared types and widths for the push-button conditioner.
package button_conditioner_pkg;

    localparam int STATE_W = 3;
    localparam int PCNT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_HELD         = 3'd2,
        ST_REPEAT       = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous 1-bit level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw button into a one-cycle press strobe, with optional auto-repeat,
// plus a debounced level, pulse counter and state for LEDs/debug.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    input  logic               repeat_en,
    output logic               pulse,
    output logic               level,
    output logic [PCNT_W-1:0]  pulse_count,
    output logic [STATE_W-1:0] fsm_state
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    logic s;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic               pulse_q, pulse_d;
    logic               level_q, level_d;
    logic [PCNT_W-1:0]  count_q, count_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn),
        .q_o (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        level_d = level_q;

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                // Release is checked first so it always beats a due repeat.
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (repeat_en && rcnt_q == RD_LAST) begin
                    state_d = ST_REPEAT;
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else if (repeat_en) begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end else begin
                    rcnt_d = '0;
                end
            end
            ST_REPEAT: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (!repeat_en) begin
                    state_d = ST_HELD;
                    rcnt_d  = '0;
                end else if (rcnt_q == RP_LAST) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                // A short dip while held is a glitch: resume holding without a new pulse.
                if (s) begin
                    state_d = ST_HELD;
                    rcnt_d  = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rcnt_d  = '0;
            end
        endcase

        count_d = pulse_d ? count_q + PCNT_W'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    assign pulse       = pulse_q;
    assign level       = level_q;
    assign pulse_count = count_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: scenarios queue the edges at which pulses are due; a monitor pops on each pulse.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    typedef struct {
        int e;
        int c;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               btn = 1'b0;
    logic               repeat_en = 1'b0;
    logic               pulse;
    logic               level;
    logic [PCNT_W-1:0]  pulse_count;
    logic [STATE_W-1:0] fsm_state;

    int   ecount = 0;
    int   tests  = 0;
    int   fails  = 0;
    exp_t sb[$];

    button_conditioner dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .repeat_en   (repeat_en),
        .pulse       (pulse),
        .level       (level),
        .pulse_count (pulse_count),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    // Index of the next rising edge; after edge i it holds i+1.
    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, ecount - 1);
        end
    endtask

    task automatic expect_pulse(input int e, input int c);
        exp_t x;
        x.e = e;
        x.c = c;
        sb.push_back(x);
    endtask

    // Drive btn=b so that the next n rising edges sample it; returns on a falling edge.
    task automatic hold(input logic b, input int n);
        btn = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b0;
        btn       = 1'b0;
        repeat_en = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_rst_pulse"}, int'(pulse), 0);
        chk({tag, "_rst_level"}, int'(level), 0);
        chk({tag, "_rst_count"}, int'(pulse_count), 0);
        chk({tag, "_rst_state"}, int'(fsm_state), int'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int   b;
        logic bounce [9];
        bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        fork
            forever begin
                exp_t x;
                @(negedge clk);
                if (pulse) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pulse actual edge=%0d count=%0d required no pulse",
                                 ecount - 1, pulse_count);
                    end else begin
                        x = sb.pop_front();
                        chk("pulse_edge", ecount - 1, x.e);
                        chk("pulse_count_at_pulse", int'(pulse_count), x.c);
                    end
                end
            end
        join_none

        @(negedge clk);

        // Clean press, no repeat
        do_reset("clean");
        b = ecount;
        expect_pulse(b + 6, 1);
        hold(1'b1, 6);
        chk("clean_level_before", int'(level), 0);
        hold(1'b1, 1);
        chk("clean_level_rise", int'(level), 1);
        chk("clean_state_held", int'(fsm_state), int'(ST_HELD));
        hold(1'b1, 13);
        hold(1'b0, 6);
        chk("clean_level_still_high", int'(level), 1);
        hold(1'b0, 1);
        chk("clean_level_fall", int'(level), 0);
        chk("clean_state_idle", int'(fsm_state), int'(ST_IDLE));
        chk("clean_count", int'(pulse_count), 1);
        chk("clean_sb_empty", sb.size(), 0);

        // Bounce rejection
        do_reset("bounce");
        for (int i = 0; i < 9; i++) hold(bounce[i], 1);
        hold(1'b0, 10);
        chk("bounce_level", int'(level), 0);
        chk("bounce_state", int'(fsm_state), int'(ST_IDLE));
        chk("bounce_count", int'(pulse_count), 0);

        // Auto-repeat
        do_reset("repeat");
        repeat_en = 1'b1;
        b = ecount;
        expect_pulse(b + 6, 1);
        expect_pulse(b + 22, 2);
        expect_pulse(b + 30, 3);
        expect_pulse(b + 38, 4);
        hold(1'b1, 23);
        chk("repeat_state", int'(fsm_state), int'(ST_REPEAT));
        hold(1'b1, 17);
        hold(1'b0, 6);
        chk("repeat_level_still_high", int'(level), 1);
        hold(1'b0, 1);
        chk("repeat_level_fall", int'(level), 0);
        hold(1'b0, 4);
        chk("repeat_count", int'(pulse_count), 4);
        chk("repeat_sb_empty", sb.size(), 0);

        // Release glitch
        do_reset("glitch");
        b = ecount;
        expect_pulse(b + 6, 1);
        hold(1'b1, 10);
        chk("glitch_state_held", int'(fsm_state), int'(ST_HELD));
        hold(1'b0, 2);
        hold(1'b1, 1);
        chk("glitch_state_relwait", int'(fsm_state), int'(ST_RELEASE_WAIT));
        chk("glitch_level_mid", int'(level), 1);
        hold(1'b1, 5);
        chk("glitch_state_back", int'(fsm_state), int'(ST_HELD));
        chk("glitch_level_after", int'(level), 1);
        hold(1'b0, 6);
        chk("glitch_level_before_fall", int'(level), 1);
        hold(1'b0, 1);
        chk("glitch_level_fall", int'(level), 0);
        chk("glitch_count", int'(pulse_count), 1);
        chk("glitch_sb_empty", sb.size(), 0);

        // Reset while held
        do_reset("midhold");
        b = ecount;
        expect_pulse(b + 6, 1);
        hold(1'b1, 10);
        chk("midhold_count_pre", int'(pulse_count), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midhold_rst_pulse", int'(pulse), 0);
        chk("midhold_rst_level", int'(level), 0);
        chk("midhold_rst_count", int'(pulse_count), 0);
        chk("midhold_rst_state", int'(fsm_state), int'(ST_IDLE));
        repeat (2) @(negedge clk);
        chk("midhold_rst_level_end", int'(level), 0);
        rst = 1'b1;
        b = ecount;
        expect_pulse(b + 6, 1);
        hold(1'b1, 6);
        chk("midhold_level_before", int'(level), 0);
        hold(1'b1, 1);
        chk("midhold_level_rise", int'(level), 1);
        chk("midhold_count", int'(pulse_count), 1);
        hold(1'b0, 8);
        chk("midhold_level_fall", int'(level), 0);
        chk("midhold_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
